wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the pipeline writeback stage
//  (resultW/writeRegW/regWriteW) and a multi-cycle mul/div unit returning late results.
//  Late results wait in a small FIFO and drain only in cycles where the pipeline does not write.
//  A starvation counter raises a stall to the hazard unit so the FIFO always drains.
//  Provides pending-register lookups so the hazard unit can stall on pending destinations.
// PARAMETERS
//  WIDTH       32  data width of register-file write data
//  AW          5   register address width
//  DEPTH       2   mul/div result FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive blocked cycles before stall_wb asserts (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  regWriteW   in   1      pipeline W-stage write enable
//  writeRegW   in   AW     pipeline W-stage destination
//  resultW     in   WIDTH  pipeline W-stage result (WriteBack mux output)
//  md_valid    in   1      mul/div result offered
//  md_ready    out  1      FIFO accepts offer this cycle
//  md_reg      in   AW     mul/div destination register
//  md_data     in   WIDTH  mul/div result
//  rf_we       out  1      register-file write enable
//  rf_wa       out  AW     register-file write address
//  rf_wd       out  WIDTH  register-file write data
//  stall_wb    out  1      registered; hazard unit must freeze M/W and bubble W (regWriteW=0)
//  md_pending  out  1      at least one valid FIFO entry
//  chk_rs      in   AW     source register query A (decode stage)
//  chk_rt      in   AW     source register query B
//  hit_rs      out  1      chk_rs!=0 and matches a valid FIFO entry (combinational)
//  hit_rt      out  1      same for chk_rt
// BEHAVIOUR
//  Reset (async): FIFO empty, all entry valid bits 0, starve_cnt=0, stall_wb=0.
//   While reset high: rf_we=0, md_ready=0, md_pending=0, hit_rs=hit_rt=0.
//  Enqueue: md_valid&md_ready at posedge stores {md_reg,md_data}; md_ready = !full (state only).
//   md_reg==0: handshake completes, nothing stored. No bypass: earliest write is next cycle.
//   Full: md_ready=0 even if a dequeue occurs same cycle (no pass-through).
//  Grant (combinational, same cycle as W stage):
//   regWriteW=1 -> rf_we=1, rf_wa=writeRegW, rf_wd=resultW (pipeline always wins).
//   else head valid -> rf_we=1, rf_wa/rf_wd from FIFO head; head pops at posedge.
//   else rf_we=0, rf_wa=0, rf_wd=0.
//  Squashed entries (valid=0) are popped silently and do not assert rf_we.
//   They are skipped in the same cycle: grant goes to first valid entry from head.
//  WAW squash: pipeline write to R!=0 clears valid of every FIFO entry with reg R
//   (pipeline instruction is younger). Entry enqueued same cycle with reg R is not squashed.
//  Starvation: starve_cnt increments (saturating at STARVE_MAX) each cycle md_pending=1
//   and FIFO not granted; clears on FIFO grant or when FIFO empty.
//   stall_wb=1 in the cycle after starve_cnt reaches STARVE_MAX; FIFO is granted that cycle.
//   stall_wb drops the cycle after the grant.
//   regWriteW=1 while stall_wb=1 is a protocol error: pipeline still wins, cnt stays saturated.
//  md_pending = any valid entry. Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  Reset mid-operation discards all FIFO contents; pending results are lost by design.
// TESTING
//  1 idle pipe; md $8=0x1234 -> md_ready=1; next cycle rf_we=1,wa=8,wd=0x1234; FIFO empty.
//  2 regWriteW=1 every cycle; md $9 enqueued -> stall_wb=1 after STARVE_MAX+1 cycles.
//    Bench then bubbles W; that cycle rf_wa=9.
//  3 two md results, pipe busy -> md_ready=0 on 3rd offer.
//    Pipe idles -> $a,$b written in order, one per cycle.
//  4 FIFO holds $10=0xAA, then pipeline writes $10=0xBB -> entry squashed.
//    Final $10=0xBB; no rf_we with 0xAA.
//  5 md offer with md_reg=0 -> accepted, md_pending stays 0; chk_rs=0 -> hit_rs=0.
//  6 assert reset with 2 entries queued -> rf_we=0, md_pending=0.
//    After release: md_ready=1 and no stale writes.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the writeback stage / mul-div unit / hazard unit and the
// register-file write-port arbiter.
interface wb_port_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             regWriteW;
  logic [AW-1:0]    writeRegW;
  logic [WIDTH-1:0] resultW;
  logic             md_valid;
  logic             md_ready;
  logic [AW-1:0]    md_reg;
  logic [WIDTH-1:0] md_data;
  logic             rf_we;
  logic [AW-1:0]    rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic             stall_wb;
  logic             md_pending;
  logic [AW-1:0]    chk_rs;
  logic [AW-1:0]    chk_rt;
  logic             hit_rs;
  logic             hit_rt;

  modport slave (
    input  regWriteW, writeRegW, resultW, md_valid, md_reg, md_data, chk_rs, chk_rt,
    output md_ready, rf_we, rf_wa, rf_wd, stall_wb, md_pending, hit_rs, hit_rt
  );

  modport master (
    output regWriteW, writeRegW, resultW, md_valid, md_reg, md_data, chk_rs, chk_rt,
    input  md_ready, rf_we, rf_wa, rf_wd, stall_wb, md_pending, hit_rs, hit_rt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W stage and late mul/div
// results queued in a small FIFO; the pipeline always wins, the FIFO drains in idle slots.
module wb_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]    r_reg  [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic             w_md_ready, w_push, w_found, w_fifo_gnt, w_pending;
  logic [PW-1:0]    w_sel, w_scan_idx, w_clr_idx;
  logic [CW-1:0]    w_lead, w_pop;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_hit_rs, w_hit_rt;

  assign w_md_ready = (r_count != CW'(DEPTH)) && !reset;
  assign w_push     = bus.md_valid && w_md_ready && (bus.md_reg != '0);
  assign w_pending  = |r_vld;

  // Walk from the head: squashed entries ahead of the first live one are skipped this cycle
  always_comb begin
    w_found    = 1'b0;
    w_sel      = '0;
    w_lead     = '0;
    w_scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PW'(k);
      if (!w_found && (CW'(k) < r_count)) begin
        if (r_vld[w_scan_idx]) begin
          w_found = 1'b1;
          w_sel   = w_scan_idx;
        end else begin
          w_lead = w_lead + 1'b1;
        end
      end
    end
  end

  assign w_fifo_gnt = !bus.regWriteW && w_found;
  assign w_pop      = w_lead + CW'(w_fifo_gnt);

  always_comb begin
    w_vld_nxt = r_vld;
    w_clr_idx = '0;
    // The W-stage instruction is younger, so its write kills any queued write to the same reg
    if (bus.regWriteW && (bus.writeRegW != '0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_reg[i] == bus.writeRegW) w_vld_nxt[i] = 1'b0;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_clr_idx = r_head + PW'(k);
      if (CW'(k) < w_pop) w_vld_nxt[w_clr_idx] = 1'b0;
    end
    if (w_push) w_vld_nxt[r_tail] = 1'b1;
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!w_pending || w_fifo_gnt) begin
      w_starve_nxt = '0;
    end else if (r_starve != SW'(STARVE_MAX)) begin
      w_starve_nxt = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_vld    <= w_vld_nxt;
      r_head   <= r_head + PW'(w_pop);
      r_tail   <= r_tail + PW'(w_push);
      r_count  <= r_count + CW'(w_push) - w_pop;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == SW'(STARVE_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[r_tail]  <= bus.md_reg;
      r_data[r_tail] <= bus.md_data;
    end
  end

  always_comb begin
    w_hit_rs = 1'b0;
    w_hit_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_reg[i] == bus.chk_rs)) w_hit_rs = 1'b1;
      if (r_vld[i] && (r_reg[i] == bus.chk_rt)) w_hit_rt = 1'b1;
    end
  end

  assign bus.md_ready   = w_md_ready;
  assign bus.md_pending = w_pending && !reset;
  assign bus.hit_rs     = w_hit_rs && (bus.chk_rs != '0) && !reset;
  assign bus.hit_rt     = w_hit_rt && (bus.chk_rt != '0) && !reset;
  assign bus.stall_wb   = r_stall;
  assign bus.rf_we      = (bus.regWriteW || w_found) && !reset;
  assign bus.rf_wa      = reset ? '0 : bus.regWriteW ? bus.writeRegW :
                          w_found ? r_reg[w_sel] : '0;
  assign bus.rf_wd      = reset ? '0 : bus.regWriteW ? bus.resultW :
                          w_found ? r_data[w_sel] : '0;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: fixed cycle-by-cycle vectors with
// hand-computed expectations for grant, starvation stall, squash and reset.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.WIDTH(32), .AW(5)) bus ();

  wb_port_arbiter #(.WIDTH(32), .AW(5), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] ra, input logic [31:0] d);
    bus.regWriteW = we;
    bus.writeRegW = ra;
    bus.resultW   = d;
  endtask

  task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.md_valid = v;
    bus.md_reg   = r;
    bus.md_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b1, 5'd3, 32'h55);
    md(1'b0, 5'd0, 32'h0);
    bus.chk_rs = 5'd0;
    bus.chk_rt = 5'd0;

    // reset state, pipeline write request masked
    @(negedge clk);
    chk_vec("rst_rf_we", bus.rf_we, 1'b0);
    chk_vec("rst_md_ready", bus.md_ready, 1'b0);
    chk_vec("rst_pending", bus.md_pending, 1'b0);
    chk_vec("rst_stall", bus.stall_wb, 1'b0);
    nxt();
    reset = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);

    // 1: idle pipe, $8 written the cycle after acceptance
    md(1'b1, 5'd8, 32'h1234);
    @(negedge clk);
    chk_vec("t1_ready", bus.md_ready, 1'b1);
    chk_vec("t1_no_bypass", bus.rf_we, 1'b0);
    nxt();
    md(1'b0, 5'd0, 32'h0);
    bus.chk_rs = 5'd8;
    bus.chk_rt = 5'd9;
    @(negedge clk);
    chk_vec("t1_we", bus.rf_we, 1'b1);
    chk_vec("t1_wa", bus.rf_wa, 5'd8);
    chk_vec("t1_wd", bus.rf_wd, 32'h1234);
    chk_vec("t1_pending", bus.md_pending, 1'b1);
    chk_vec("t1_hit_rs", bus.hit_rs, 1'b1);
    chk_vec("t1_hit_rt", bus.hit_rt, 1'b0);
    nxt();
    @(negedge clk);
    chk_vec("t1_empty", bus.md_pending, 1'b0);
    chk_vec("t1_idle_we", bus.rf_we, 1'b0);
    chk_vec("t1_idle_wa", bus.rf_wa, 5'd0);
    chk_vec("t1_hit_gone", bus.hit_rs, 1'b0);
    nxt();
    bus.chk_rs = 5'd0;
    bus.chk_rt = 5'd0;

    // 2: pipeline busy every cycle, $9 starves until stall_wb
    pipe(1'b1, 5'd3, 32'h55);
    md(1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk_vec("t2_pipe_wins", bus.rf_wa, 5'd3);
    nxt();
    md(1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_vec($sformatf("t2_nostall_c%0d", i), bus.stall_wb, 1'b0);
      chk_vec($sformatf("t2_wd_c%0d", i), bus.rf_wd, 32'h55);
      nxt();
    end
    pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_vec("t2_stall", bus.stall_wb, 1'b1);
    chk_vec("t2_we", bus.rf_we, 1'b1);
    chk_vec("t2_wa", bus.rf_wa, 5'd9);
    chk_vec("t2_wd", bus.rf_wd, 32'h99);
    nxt();
    @(negedge clk);
    chk_vec("t2_stall_drop", bus.stall_wb, 1'b0);
    chk_vec("t2_empty", bus.md_pending, 1'b0);
    nxt();

    // 3: two results fill the FIFO while the pipe is busy, then drain in order
    pipe(1'b1, 5'd3, 32'h55);
    md(1'b1, 5'd10, 32'hA0);
    @(negedge clk);
    chk_vec("t3_rdy0", bus.md_ready, 1'b1);
    nxt();
    md(1'b1, 5'd11, 32'hB0);
    @(negedge clk);
    chk_vec("t3_rdy1", bus.md_ready, 1'b1);
    nxt();
    md(1'b1, 5'd12, 32'hC0);
    @(negedge clk);
    chk_vec("t3_full", bus.md_ready, 1'b0);
    nxt();
    md(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_vec("t3_wa_a", bus.rf_wa, 5'd10);
    chk_vec("t3_wd_a", bus.rf_wd, 32'hA0);
    nxt();
    @(negedge clk);
    chk_vec("t3_wa_b", bus.rf_wa, 5'd11);
    chk_vec("t3_wd_b", bus.rf_wd, 32'hB0);
    nxt();
    @(negedge clk);
    chk_vec("t3_done", bus.rf_we, 1'b0);
    nxt();

    // 4: queued $16 squashed by a younger pipeline write; $17 behind it granted by skip
    md(1'b1, 5'd16, 32'hAA);
    pipe(1'b1, 5'd3, 32'h55);
    nxt();
    md(1'b1, 5'd17, 32'hCC);
    pipe(1'b1, 5'd16, 32'hBB);
    bus.chk_rs = 5'd16;
    @(negedge clk);
    chk_vec("t4_wa", bus.rf_wa, 5'd16);
    chk_vec("t4_wd", bus.rf_wd, 32'hBB);
    chk_vec("t4_hit_before", bus.hit_rs, 1'b1);
    nxt();
    md(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_vec("t4_hit_after", bus.hit_rs, 1'b0);
    chk_vec("t4_skip_wa", bus.rf_wa, 5'd17);
    chk_vec("t4_skip_wd", bus.rf_wd, 32'hCC);
    nxt();
    @(negedge clk);
    chk_vec("t4_no_stale", bus.rf_we, 1'b0);
    chk_vec("t4_empty", bus.md_pending, 1'b0);
    chk_vec("t4_ready", bus.md_ready, 1'b1);
    nxt();
    bus.chk_rs = 5'd0;

    // 5: md_reg 0 is accepted but never stored
    md(1'b1, 5'd0, 32'h77);
    @(negedge clk);
    chk_vec("t5_ready", bus.md_ready, 1'b1);
    nxt();
    md(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_vec("t5_pending", bus.md_pending, 1'b0);
    chk_vec("t5_we", bus.rf_we, 1'b0);
    chk_vec("t5_hit_rs0", bus.hit_rs, 1'b0);
    chk_vec("t5_hit_rt0", bus.hit_rt, 1'b0);
    nxt();

    // 6: reset with two entries queued discards them
    pipe(1'b1, 5'd3, 32'h55);
    md(1'b1, 5'd5, 32'h50);
    nxt();
    md(1'b1, 5'd6, 32'h60);
    nxt();
    md(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_vec("t6_queued", bus.md_pending, 1'b1);
    nxt();
    reset = 1'b1;
    @(negedge clk);
    chk_vec("t6_rst_we", bus.rf_we, 1'b0);
    chk_vec("t6_rst_pending", bus.md_pending, 1'b0);
    chk_vec("t6_rst_ready", bus.md_ready, 1'b0);
    nxt();
    reset = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk_vec("t6_ready", bus.md_ready, 1'b1);
    chk_vec("t6_no_stale0", bus.rf_we, 1'b0);
    chk_vec("t6_pending", bus.md_pending, 1'b0);
    nxt();
    @(negedge clk);
    chk_vec("t6_no_stale1", bus.rf_we, 1'b0);
    chk_vec("t6_stall", bus.stall_wb, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
